bcd_conv_arbiter: RTL and testbench
===================================

Name: bcd_conv_arbiter

Overview:
Round-robin arbiter and sequencer that shares one multi-cycle binary-to-BCD converter among NUM_REQ display clients, e.g. live timer, best-score register and message source. It grants one client, launches the converter, waits for completion and returns the packed BCD result to the granted client. It sits between the game-control FSMs and the shared converter, ahead of the seven-segment decode and display mux.

Parameters:
NUM_REQ, 4, number of requesting clients (2..8)
MAX_VAL, 9999, largest operand forwarded to the converter; larger operands are clamped
TIMEOUT_CYCLES, 64, converter watchdog limit in clk cycles (used only with BCD_ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-client request level, held until gnt
req_bin  input  16*NUM_REQ  packed operands; client i occupies bits [16*i+15:16*i]
gnt  output  NUM_REQ  one-hot grant pulse, one cycle
rsp_valid  output  NUM_REQ  one-hot result-valid pulse, one cycle
rsp_bcd  output  16  {bcd3,bcd2,bcd1,bcd0} of the last result, held until next result
rsp_ovf  output  1  last operand was clamped to MAX_VAL
rsp_err  output  1  last conversion timed out
busy  output  1  high in every state except S_IDLE
conv_start  output  1  one-cycle converter launch pulse
conv_bin  output  16  operand to converter, stable from S_LAUNCH through end of S_WAIT
conv_done  input  1  converter completion pulse
conv_bcd  input  16  converter result, valid when conv_done=1

Behaviour:
- Reset: the arbiter is in S_IDLE. gnt, rsp_valid, conv_start, rsp_ovf, rsp_err and busy are 0. rsp_bcd and conv_bin are 0. Round-robin pointer last_idx = NUM_REQ-1, so client 0 has first priority.
- All outputs are registered. No combinational path runs from req or conv_done to any output.
- State S_IDLE:
  - If req != 0, select the first set bit scanning last_idx+1, last_idx+2, ... modulo NUM_REQ.
  - Latch idx and that client's operand.
  - If operand > MAX_VAL, latch MAX_VAL and set ovf_pend=1. Otherwise ovf_pend=0.
  - Go to S_LAUNCH.
- State S_LAUNCH (1 cycle): gnt[idx]=1, conv_start=1, conv_bin = latched operand. Go to S_WAIT.
- State S_WAIT:
  - conv_done is sampled only in this state. A conv_done seen during S_IDLE or S_LAUNCH is ignored.
  - On conv_done: capture conv_bcd and go to S_RESP.
- State S_RESP (1 cycle):
  - rsp_valid[idx]=1.
  - rsp_bcd updates on entry, together with rsp_ovf=ovf_pend and rsp_err=0 (or 1 on timeout).
  - last_idx=idx. Go to S_IDLE.
- Client handshake: client drops req on the cycle after seeing gnt. A req bit still high in S_IDLE after its own response counts as a new request.
- req deasserted before S_IDLE samples it gets no grant. req changes during S_LAUNCH, S_WAIT or S_RESP are ignored.
- Latency:
  - req is sampled at the S_IDLE edge; gnt appears 1 cycle later.
  - rsp_valid appears 1 cycle after conv_done.
  - Minimum request-to-request period = 3 cycles + converter latency.
- Fairness: with all clients continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0,...
- Reset mid-operation (async, any state): immediate return to reset values. In-flight result is discarded and no rsp_valid is issued. The converter must share rst_n.
- Widths:
  - MAX_VAL compare is unsigned 16-bit.
  - idx and last_idx are $clog2(NUM_REQ) bits; wrap uses explicit modulo for non-power-of-2 NUM_REQ.

Optional Feature:
BCD_ARB_TIMEOUT_EN
- Defined:
  - Counter wd_cnt ($clog2(TIMEOUT_CYCLES+1) bits) clears on entry to S_WAIT and increments each S_WAIT cycle.
  - If wd_cnt reaches TIMEOUT_CYCLES-1 without conv_done, go to S_RESP with rsp_bcd=16'hFFFF, rsp_err=1, rsp_ovf=ovf_pend.
  - conv_done arriving in that same cycle wins: normal result, rsp_err=0.
- Undefined: no counter. S_WAIT waits indefinitely. rsp_err is tied to 0 and the port remains present.

Test Plan:
- Single client 2: req=4'b0100, req_bin[47:32]=16'd1234, converter done after 20 cycles returning 16'h1234 -> gnt=4'b0100 pulse one cycle after request, conv_bin=1234, rsp_valid=4'b0100, rsp_bcd=16'h1234, rsp_ovf=0.
- Contention from reset: req=4'b1111 held and re-raised after each rsp -> grant order 0,1,2,3,0. Exactly one gnt bit per grant; busy low for exactly one cycle between transactions.
- Overflow: client 1 operand 16'd12345 -> conv_bin=9999, rsp_ovf=1. A following operand of 500 -> rsp_ovf=0, rsp_bcd=16'h0500.
- Spurious done: conv_done pulsed in S_IDLE and in S_LAUNCH -> no state change. Real done at cycle 5 of S_WAIT -> single rsp_valid.
- Reset mid-S_WAIT: assert rst_n=0 for 2 cycles -> outputs zero immediately, no rsp_valid. Next request from client 3 alone is granted normally (last_idx=3 after reset).
- BCD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, converter never finishes -> rsp_valid after 64 S_WAIT cycles with rsp_bcd=16'hFFFF, rsp_err=1. Done on cycle 64 exactly -> normal result, rsp_err=0.

Source files
------------

// File: rtl/bcd_conv_arbiter_if.sv
// ---------------------------------------------------------------------------
// bcd_conv_arbiter_if
//   Bundle of the client-side request/response signals and the shared
//   binary-to-BCD converter handshake used by bcd_conv_arbiter.
//
//   Client side   : req, req_bin (in), gnt, rsp_valid, rsp_bcd, rsp_ovf,
//                   rsp_err, busy (out)
//   Converter side: conv_start, conv_bin (out), conv_done, conv_bcd (in)
//
//   Modports:
//     slave  - the arbiter itself (receives requests, drives the converter)
//     master - the environment (clients plus converter)
// ---------------------------------------------------------------------------
interface bcd_conv_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_bin;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [15:0]           rsp_bcd;
  logic                  rsp_ovf;
  logic                  rsp_err;
  logic                  busy;
  logic                  conv_start;
  logic [15:0]           conv_bin;
  logic                  conv_done;
  logic [15:0]           conv_bcd;

  modport slave (
    input  req, req_bin, conv_done, conv_bcd,
    output gnt, rsp_valid, rsp_bcd, rsp_ovf, rsp_err, busy,
           conv_start, conv_bin
  );

  modport master (
    output req, req_bin, conv_done, conv_bcd,
    input  gnt, rsp_valid, rsp_bcd, rsp_ovf, rsp_err, busy,
           conv_start, conv_bin
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// ---------------------------------------------------------------------------
// bcd_conv_arbiter
//   Round-robin arbiter/sequencer sharing one multi-cycle binary-to-BCD
//   converter among NUM_REQ display clients. One client is granted, its
//   operand (clamped to MAX_VAL) is sent to the converter, and the packed BCD
//   result is returned with a one-hot rsp_valid pulse to that client.
//
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset (shared with the converter)
//   bus    - bcd_conv_arbiter_if.slave:
//              req/req_bin          client requests and packed operands
//              gnt/rsp_valid        one-hot, one-cycle grant / result pulses
//              rsp_bcd/ovf/err      last result, held until the next one
//              busy                 high whenever not idle
//              conv_start/conv_bin  converter launch pulse and operand
//              conv_done/conv_bcd   converter completion and result
//
// Optional feature macro: BCD_ARB_TIMEOUT_EN
//   Defined   - a watchdog ends S_WAIT after TIMEOUT_CYCLES cycles with
//               rsp_bcd=16'hFFFF and rsp_err=1.
//   Undefined - S_WAIT waits indefinitely; rsp_err is constant 0.
//
// All outputs come straight from flops; req and conv_done only reach them
// through the next-state logic.
// ---------------------------------------------------------------------------
module bcd_conv_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_VAL        = 9999,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_conv_arbiter_if.slave bus
);

  localparam int          IDX_W     = $clog2(NUM_REQ);
  localparam logic [15:0] MAX_VAL16 = 16'(MAX_VAL);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("bcd_conv_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_last_idx;
  logic [15:0]        r_op;
  logic               r_ovf_pend;

  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [15:0]        r_rsp_bcd;
  logic               r_rsp_ovf;
  logic               r_busy;
  logic               r_conv_start;

  logic               w_sel_found;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [15:0]        w_sel_bin;
  int                 w_best_dist;
  logic               w_sel_ovf;
  logic               w_timeout;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: the requester with the smallest distance past
  // r_last_idx wins. Distance is taken modulo NUM_REQ so non-power-of-2
  // client counts wrap correctly.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sel_bin   = '0;
    w_best_dist = NUM_REQ;
    for (int c = 0; c < NUM_REQ; c++) begin
      if (bus.req[c] &&
          (((c - int'(r_last_idx) - 1 + NUM_REQ) % NUM_REQ) < w_best_dist)) begin
        w_best_dist = (c - int'(r_last_idx) - 1 + NUM_REQ) % NUM_REQ;
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(c);
        w_sel_bin   = bus.req_bin[16*c +: 16];
      end
    end
  end

  assign w_sel_ovf = (w_sel_bin > MAX_VAL16);

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_rsp_err;

  // Held at zero outside S_WAIT, so it starts from zero on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) &&
                     (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // A conv_done in the watchdog's last cycle takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_err <= 1'b0;
    end else if (r_state == S_WAIT && (bus.conv_done || w_timeout)) begin
      r_rsp_err <= !bus.conv_done;
    end
  end

  assign bus.rsp_err = r_rsp_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; conv_done only matters in S_WAIT
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_sel_found) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT:   if (bus.conv_done || w_timeout) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs and per-transaction context. gnt/conv_start are set
  // on the edge into S_LAUNCH and rsp_valid on the edge into S_RESP, so each
  // pulse lasts exactly that one-cycle state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_last_idx   <= IDX_W'(NUM_REQ - 1);
      r_op         <= '0;
      r_ovf_pend   <= 1'b0;
      r_gnt        <= '0;
      r_rsp_valid  <= '0;
      r_rsp_bcd    <= '0;
      r_rsp_ovf    <= 1'b0;
      r_busy       <= 1'b0;
      r_conv_start <= 1'b0;
    end else begin
      r_gnt        <= '0;
      r_rsp_valid  <= '0;
      r_conv_start <= 1'b0;
      r_busy       <= (w_state_nxt != S_IDLE);

      unique case (r_state)
        S_IDLE: begin
          if (w_sel_found) begin
            r_idx        <= w_sel_idx;
            r_op         <= w_sel_ovf ? MAX_VAL16 : w_sel_bin;
            r_ovf_pend   <= w_sel_ovf;
            r_gnt        <= onehot(w_sel_idx);
            r_conv_start <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.conv_done || w_timeout) begin
            r_rsp_bcd   <= bus.conv_done ? bus.conv_bcd : 16'hFFFF;
            r_rsp_ovf   <= r_ovf_pend;
            r_rsp_valid <= onehot(r_idx);
            r_last_idx  <= r_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_bcd    = r_rsp_bcd;
  assign bus.rsp_ovf    = r_rsp_ovf;
  assign bus.busy       = r_busy;
  assign bus.conv_start = r_conv_start;
  assign bus.conv_bin   = r_op;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bcd_conv_arbiter
//   Self-checking bench for bcd_conv_arbiter. The bench plays both the
//   display clients and the shared converter. A transaction-level model
//   (pending-request mask, round-robin pointer, clamp and decimal digit
//   arithmetic) predicts every grant and response.
// ---------------------------------------------------------------------------
module tb_bcd_conv_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int MAX_VAL  = 9999;
  localparam int TIMEOUT  = 64;

  localparam int M_NORMAL  = 0;
  localparam int M_TIMEOUT = 1;
  localparam int M_ABORT   = 2;

  logic clk;
  logic rst_n;

  bcd_conv_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_if ();

  bcd_conv_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .MAX_VAL       (MAX_VAL),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_mis;

  // Reference-model state
  logic [NUM_REQ-1:0] m_pend;
  logic [15:0]        m_op [NUM_REQ];
  int                 m_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] pend, input int last);
    int c;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (last + k) % NUM_REQ;
      if (pend[c]) return c;
    end
    return 0;
  endfunction

  function automatic logic [15:0] clamp(input logic [15:0] v);
    return (int'(v) > MAX_VAL) ? 16'(MAX_VAL) : v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 16'(10000 + $urandom_range(0, 55535));
      1:       return 16'd9999;
      2:       return 16'd10000;
      3:       return 16'hFFFF;
      4:       return 16'd0;
      default: return 16'($urandom_range(0, 9999));
    endcase
  endfunction

  task automatic drive_clients();
    for (int i = 0; i < NUM_REQ; i++) bus_if.req_bin[16*i +: 16] = m_op[i];
    bus_if.req = m_pend;
  endtask

  task automatic add_random_reqs();
    logic [NUM_REQ-1:0] nm;
    nm = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)) & ~m_pend;
    for (int i = 0; i < NUM_REQ; i++) if (nm[i]) m_op[i] = rand_op();
    m_pend = m_pend | nm;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus_if.conv_done = 1'b0;
    m_pend = '0;
    m_last = NUM_REQ - 1;
    drive_clients();
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 64'({bus_if.gnt, bus_if.rsp_valid, bus_if.busy, bus_if.conv_start,
                          bus_if.rsp_ovf, bus_if.rsp_err}), 64'd0);
    chk("rst_data", 64'({bus_if.conv_bin, bus_if.rsp_bcd}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full transaction, entered and left at a negedge with the DUT idle.
  task automatic run_txn(input int lat, input int mode, input bit rand_new,
                         input bit spur_idle, input bit spur_launch);
    int          idx;
    logic [15:0] ebin;
    logic [15:0] ebcd;
    logic        eovf;

    if (rand_new) add_random_reqs();
    if (m_pend == '0) begin
      m_pend = NUM_REQ'(1) << $urandom_range(0, NUM_REQ - 1);
      for (int i = 0; i < NUM_REQ; i++) if (m_pend[i]) m_op[i] = rand_op();
    end
    drive_clients();
    if (spur_idle) begin
      bus_if.conv_done = 1'b1;
      bus_if.conv_bcd  = 16'($urandom);
    end

    idx  = rr_pick(m_pend, m_last);
    ebin = clamp(m_op[idx]);
    eovf = (int'(m_op[idx]) > MAX_VAL);
    ebcd = (mode == M_TIMEOUT) ? 16'hFFFF : to_bcd(int'(ebin));

    @(negedge clk);
    bus_if.conv_done = 1'b0;
    chk("gnt", 64'(bus_if.gnt), 64'(1) << idx);
    chk("conv_start", 64'(bus_if.conv_start), 64'd1);
    chk("conv_bin", 64'(bus_if.conv_bin), 64'(ebin));
    chk("busy_launch", 64'(bus_if.busy), 64'd1);
    m_pend[idx] = 1'b0;
    drive_clients();
    if (spur_launch) begin
      bus_if.conv_done = 1'b1;
      bus_if.conv_bcd  = 16'($urandom);
    end

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      bus_if.conv_done = 1'b0;
      chk("wait_quiet", 64'({bus_if.gnt, bus_if.rsp_valid, bus_if.conv_start, bus_if.busy}), 64'd1);
      chk("conv_bin_hold", 64'(bus_if.conv_bin), 64'(ebin));
      if (rand_new && $urandom_range(0, 3) == 0) begin
        add_random_reqs();
        drive_clients();
      end
      if (k == lat && mode == M_NORMAL) begin
        bus_if.conv_done = 1'b1;
        bus_if.conv_bcd  = ebcd;
      end
    end

    if (mode == M_ABORT) begin
      rst_n = 1'b0;
      #1;
      chk("abort_ctrl", 64'({bus_if.gnt, bus_if.rsp_valid, bus_if.busy, bus_if.conv_start,
                              bus_if.rsp_ovf, bus_if.rsp_err}), 64'd0);
      chk("abort_data", 64'({bus_if.conv_bin, bus_if.rsp_bcd}), 64'd0);
      m_pend = '0;
      m_last = NUM_REQ - 1;
      drive_clients();
      repeat (2) begin
        @(negedge clk);
        chk("abort_no_rsp", 64'(bus_if.rsp_valid), 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_idle", 64'({bus_if.busy, bus_if.rsp_valid}), 64'd0);
      return;
    end

    @(negedge clk);
    bus_if.conv_done = 1'b0;
    chk("rsp_valid", 64'(bus_if.rsp_valid), 64'(1) << idx);
    chk("rsp_bcd", 64'(bus_if.rsp_bcd), 64'(ebcd));
    chk("rsp_ovf", 64'(bus_if.rsp_ovf), 64'(eovf));
    chk("rsp_err", 64'(bus_if.rsp_err), (mode == M_TIMEOUT) ? 64'd1 : 64'd0);
    chk("resp_ctrl", 64'({bus_if.gnt, bus_if.conv_start, bus_if.busy}), 64'd1);
    m_last = idx;

    @(negedge clk);
    chk("idle_gap", 64'({bus_if.rsp_valid, bus_if.busy}), 64'd0);
    chk("bcd_hold", 64'(bus_if.rsp_bcd), 64'(ebcd));
  endtask

  initial begin
    n_vec  = 0;
    n_mis  = 0;
    rst_n  = 1'b0;
    m_pend = '0;
    m_last = NUM_REQ - 1;
    for (int i = 0; i < NUM_REQ; i++) m_op[i] = '0;
    bus_if.req       = '0;
    bus_if.req_bin   = '0;
    bus_if.conv_done = 1'b0;
    bus_if.conv_bcd  = '0;
    repeat (2) @(negedge clk);
    apply_reset();

    // Single client 2, operand 1234, converter latency 20
    m_op[2] = 16'd1234;
    m_pend  = 4'b0100;
    run_txn(20, M_NORMAL, 1'b0, 1'b0, 1'b0);

    // Full contention from reset, each client re-raising after its response
    apply_reset();
    m_pend = '1;
    for (int i = 0; i < NUM_REQ; i++) m_op[i] = rand_op();
    for (int t = 0; t < 5; t++) begin
      run_txn($urandom_range(1, 6), M_NORMAL, 1'b0, 1'b0, 1'b0);
      if (t < 4) begin
        m_pend[m_last] = 1'b1;
        m_op[m_last]   = rand_op();
      end
    end

    // Overflow clamp followed by an in-range operand
    apply_reset();
    m_op[1] = 16'd12345;
    m_pend  = 4'b0010;
    run_txn(3, M_NORMAL, 1'b0, 1'b0, 1'b0);
    m_op[1] = 16'd500;
    m_pend  = 4'b0010;
    run_txn(4, M_NORMAL, 1'b0, 1'b0, 1'b0);

    // Spurious done in S_IDLE and S_LAUNCH, real done in wait cycle 5
    run_txn(5, M_NORMAL, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of S_WAIT, then client 3 alone
    run_txn(30, M_ABORT, 1'b1, 1'b0, 1'b0);
    m_op[3] = 16'd4321;
    m_pend  = 4'b1000;
    run_txn(2, M_NORMAL, 1'b0, 1'b0, 1'b0);

`ifdef BCD_ARB_TIMEOUT_EN
    run_txn(TIMEOUT, M_TIMEOUT, 1'b1, 1'b0, 1'b0);
    run_txn(TIMEOUT, M_NORMAL, 1'b1, 1'b0, 1'b0);
`endif

    // Randomised traffic
    for (int t = 0; t < 150; t++) begin
      run_txn($urandom_range(1, 12), M_NORMAL, 1'b1,
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
